// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin two-port arbiter and sequencer for the single-port data memory DM
module dm_arbiter #(
  parameter int N = 7,
  parameter int TO_CYCLES = 15
) (
  input  logic          clka,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [N-1:0]  p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_ack,
  output logic [31:0]   p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [N-1:0]  p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_ack,
  output logic [31:0]   p1_rdata,
  output logic          p1_err,
  output logic          dm_ena,
  output logic          dm_wea,
  output logic [N-1:0]  dm_addra,
  output logic [31:0]   dm_dina,
  input  logic [31:0]   dm_douta,
  input  logic          dm_done,
  output logic          busy,
  output logic          gnt_id
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic rr;
  logic [7:0] cnt;
  logic pick;
  assign pick = (p0_req & p1_req) ? rr : p1_req;
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      state <= IDLE;
      rr <= 1'b0;
      cnt <= '0;
      busy <= 1'b0;
      gnt_id <= 1'b0;
      dm_ena <= 1'b0;
      dm_wea <= 1'b0;
      dm_addra <= '0;
      dm_dina <= '0;
      p0_ack <= 1'b0;
      p0_err <= 1'b0;
      p0_rdata <= '0;
      p1_ack <= 1'b0;
      p1_err <= 1'b0;
      p1_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (p0_req | p1_req) begin
          state <= ISSUE;
          busy <= 1'b1;
          gnt_id <= pick;
          rr <= ~pick;
          dm_ena <= 1'b1;
          dm_wea <= pick ? p1_we : p0_we;
          dm_addra <= pick ? p1_addr : p0_addr;
          dm_dina <= pick ? p1_wdata : p0_wdata;
        end
        ISSUE: begin
          dm_ena <= 1'b0;
          cnt <= '0;
          if (dm_wea) begin
            state <= DONE;
            p0_ack <= ~gnt_id;
            p1_ack <= gnt_id;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: if (dm_done) begin
          state <= DONE;
          p0_ack <= ~gnt_id;
          p1_ack <= gnt_id;
          if (gnt_id) p1_rdata <= dm_douta;
          else p0_rdata <= dm_douta;
        end else if (cnt == 8'(TO_CYCLES - 1)) begin
          state <= DONE;
          p0_ack <= ~gnt_id;
          p1_ack <= gnt_id;
          p0_err <= ~gnt_id;
          p1_err <= gnt_id;
          if (gnt_id) p1_rdata <= '0;
          else p0_rdata <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
          p0_ack <= 1'b0;
          p0_err <= 1'b0;
          p1_ack <= 1'b0;
          p1_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer for the single-port data memory `DM`. It shares `DM` between the pipeline memory-access stage (port 0) and the debug/loader port (port 1). It grants one request at a time in round-robin order and drives the `DM` enable, write and address/data lines from registers. It returns read data using `DM`'s `done` pulse and flags a read that never completes with an error.

## Interface
- `N`, 7, address width; must match `DM`'s `N`
- `TO_CYCLES`, 15, maximum cycles spent in WAIT before a read is aborted with error (range 2..255)

- `clka` in 1: clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `p0_req` in 1: port 0 request; held high with command stable until `p0_ack`
- `p0_we` in 1: port 0 command, 1 = write, 0 = read
- `p0_addr` in N: port 0 word address
- `p0_wdata` in 32: port 0 write data
- `p0_ack` out 1: one-cycle completion pulse for port 0
- `p0_rdata` out 32: port 0 read data, valid while `p0_ack` = 1
- `p0_err` out 1: high with `p0_ack` when the read timed out
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_ack`, `p1_rdata`, `p1_err`: port 1, identical semantics
- `dm_ena` out 1: to `DM.ena`
- `dm_wea` out 1: to `DM.wea`
- `dm_addra` out N: to `DM.addra`
- `dm_dina` out 32: to `DM.dina`
- `dm_douta` in 32: from `DM.douta`
- `dm_done` in 1: from `DM.done`; high for one cycle, one cycle after a read is issued
- `busy` out 1: high in every state except IDLE
- `gnt_id` out 1: port currently or most recently granted

## Operation
- States: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant that port.
  - If both are high, grant the port selected by the round-robin pointer `rr`.
  - On grant:
    - Latch the granted port's `we`, `addr` and `wdata` into `dm_wea`, `dm_addra` and `dm_dina`.
    - Set `dm_ena` = 1 and `gnt_id` = granted port.
    - Set `rr` = the other port.
    - Go to ISSUE.
- **ISSUE**: `dm_ena` = 1 for exactly this one cycle.
  - Write: go to DONE with the granted ack = 1 and err = 0.
  - Read: go to WAIT with the timeout counter cleared to 0.
  - `dm_ena` = 0 on exit.
- **WAIT**
  - If `dm_done` = 1: capture `dm_douta` into the granted port's `rdata`, set ack = 1, and go to DONE.
  - Otherwise increment the counter. When the counter reaches `TO_CYCLES` - 1: set ack = 1, err = 1, rdata = 0, and go to DONE.
- **DONE**
  - The ack (and err) are high for this cycle only.
  - Clear ack and err, then go to IDLE.
- Requester rule: `req` must be dropped in the cycle after `ack`. A `req` still high in IDLE is a new request.
- `pX_rdata` holds its last read value after `ack`. Writes do not alter it.
- `dm_dina` and `dm_addra` hold their last values when `dm_ena` = 0.
- The non-granted port's request is ignored until the arbiter returns to IDLE. There is no preemption.
- `dm_done` outside WAIT is ignored.

## Timing
- Reset values when `rst_n` = 0 at a rising edge:
  - state = IDLE
  - `dm_ena`, `dm_wea`, `dm_addra`, `dm_dina` = 0
  - all `ack`, `err`, `rdata` = 0
  - `busy` = 0, `gnt_id` = 0, `rr` = 0, counter = 0
- Reset mid-transaction abandons the access. No ack is issued, and a stale `dm_done` after reset is ignored.
- Write, with `req` high in cycle 0:
  - `dm_ena` and `dm_wea` high in cycle 1.
  - `DM` commits at the end of cycle 1.
  - `ack` in cycle 2.
  - IDLE in cycle 3.
  - Peak write throughput is 1 per 3 cycles.
- Read, with `req` high in cycle 0:
  - `dm_ena` high in cycle 1.
  - `dm_done` and `dm_douta` valid in cycle 2.
  - `ack` and `rdata` in cycle 3.
  - IDLE in cycle 4.
  - Peak read throughput is 1 per 4 cycles.
- Timeout read: `ack` and `err` in cycle 1 + `TO_CYCLES` + 1 after the issue cycle.
- Both requesting continuously: grants alternate 0, 1, 0, 1 starting from port 0 after reset.
- A single requester may be granted repeatedly. `rr` only changes on a grant.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with both `req` high → all outputs 0, and no `dm_ena` until the first cycle after reset releases.
- **Port 0 write then read:** write 0xDEADBEEF to addr 5, then read addr 5 → write `p0_ack` in cycle 2. Read `p0_ack` in cycle 3 of the read with `p0_rdata` = 0xDEADBEEF and `p0_err` = 0.
- **Simultaneous reads after reset:** both ports read (p0 addr 1 = 0x11, p1 addr 2 = 0x22) → port 0 served first, then port 1. `gnt_id` sequence is 0, 1. Each `rdata` is correct and each `ack` is a single-cycle pulse.
- **Sustained contention:** both ports issue 8 back-to-back writes → grants strictly alternate, 8 acks per port, and `DM` contents match all 16 writes.
- **Timeout:** tie `dm_done` = 0 with `TO_CYCLES` = 4, then read on port 1 → `p1_ack` = `p1_err` = 1 and `p1_rdata` = 0, then IDLE. A subsequent port 0 read with `DM` reconnected succeeds.
- **Reset mid-read:** drop `rst_n` in the WAIT cycle → no `ack` on either port, and a pending `p1_req` is granted in the first cycle after release.
